// File: rtl/counter_sequencer.sv
// Gated, bounded W-bit up-counter with start/stop/pause control and one-shot or auto-reload mode.
// tc and the DONE transition appear one cycle after the terminal tick edge.
module counter_sequencer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         pause,
  input  logic         tick,
  input  logic         mode,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         busy,
  output logic         done,
  output logic         tc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state, state_n;
  logic [W-1:0]   cnt_n;
  logic [W-1:0]   limit_q, limit_n;
  logic           mode_q, mode_n;
  logic           tc_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      limit_q <= '0;
      mode_q  <= 1'b0;
      tc      <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      limit_q <= limit_n;
      mode_q  <= mode_n;
      tc      <= tc_n;
    end
  end

  // Priority: stop > start > pause > tick.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    limit_n = limit_q;
    mode_n  = mode_q;
    tc_n    = 1'b0;
    if (stop) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_n = RUN;
            cnt_n   = '0;
            limit_n = limit;
            mode_n  = mode;
          end
        end
        RUN: begin
          if (pause) begin
            state_n = PAUSE;
          end else if (tick) begin
            if (cnt == limit_q) begin
              tc_n = 1'b1;
              if (mode_q) begin
                cnt_n = '0;
              end else begin
                state_n = DONE;
              end
            end else begin
              cnt_n = cnt + W'(1);
            end
          end
        end
        PAUSE: begin
          // The exit cycle deliberately drops its tick; counting resumes next cycle.
          if (!pause) begin
            state_n = RUN;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  assign busy = (state == RUN) || (state == PAUSE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer (W=3) with hand-computed expectations.
module tb_counter_sequencer;

  localparam int W = 3;

  logic         clk;
  logic         rst;
  logic         start;
  logic         stop;
  logic         pause;
  logic         tick;
  logic         mode;
  logic [W-1:0] limit;
  logic [W-1:0] cnt;
  logic         busy;
  logic         done;
  logic         tc;

  int n_tests;
  int n_fail;

  counter_sequencer #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .pause (pause),
    .tick  (tick),
    .mode  (mode),
    .limit (limit),
    .cnt   (cnt),
    .busy  (busy),
    .done  (done),
    .tc    (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle; inputs are changed and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input int c, input bit b, input bit d, input bit t);
    check({tag, ".cnt"},  32'(cnt),  32'(c));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".done"}, 32'(done), 32'(d));
    check({tag, ".tc"},   32'(tc),   32'(t));
  endtask

  task automatic do_start(input logic [W-1:0] lim, input logic m);
    start = 1'b1; limit = lim; mode = m;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    start = 1'b0; pause = 1'b0; tick = 1'b0;
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    int exp_c;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; tick = 1'b0;
    mode = 1'b0; limit = '0;
    #12;
    expect_all("reset", 0, 0, 0, 0);
    rst = 1'b0;
    step();

    // One-shot, limit 3: tick held high, including during the start cycle.
    tick = 1'b1;
    do_start(3'd3, 1'b0);
    expect_all("os3.start", 0, 1, 0, 0);
    step(); check("os3.c1", 32'(cnt), 1);
    step(); check("os3.c2", 32'(cnt), 2);
    step(); check("os3.c3", 32'(cnt), 3); check("os3.c3.tc", 32'(tc), 0);
    step(); expect_all("os3.term", 3, 0, 1, 1);
    step(); expect_all("os3.hold", 3, 0, 1, 0);

    // Auto-reload, limit 5, restarted straight from DONE.
    do_start(3'd5, 1'b1);
    expect_all("ar5.start", 0, 1, 0, 0);
    exp_c = 0;
    for (int i = 1; i <= 14; i++) begin
      step();
      check("ar5.cnt", 32'(cnt), 32'((i % 6 == 0) ? 0 : (i % 6)));
      check("ar5.tc", 32'(tc), 32'(i % 6 == 0));
      check("ar5.busy", 32'(busy), 1);
    end
    check("ar5.end", 32'(cnt), 2);

    // Auto-reload at full range: reaches 7, then reloads with tc.
    do_stop();
    expect_all("stop1", 0, 0, 0, 0);
    tick = 1'b1;
    do_start(3'd7, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      step();
      exp_c = (i == 8) ? 0 : (i > 8 ? i - 8 : i);
      check("ar7.cnt", 32'(cnt), 32'(exp_c));
      check("ar7.tc", 32'(tc), 32'(i == 8));
    end

    // Pause at cnt=2 with tick high; exit cycle drops its tick.
    do_stop();
    tick = 1'b1;
    do_start(3'd7, 1'b0);
    step(); step();
    check("pz.pre", 32'(cnt), 2);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("pz.hold", 32'(cnt), 2);
      check("pz.busy", 32'(busy), 1);
    end
    pause = 1'b0;
    step(); check("pz.exit", 32'(cnt), 2);
    step(); check("pz.c3", 32'(cnt), 3);
    step(); check("pz.c4", 32'(cnt), 4);

    // start while running is ignored (no restart, no relatch).
    tick = 1'b0; start = 1'b1; limit = 3'd1; mode = 1'b1;
    step();
    start = 1'b0;
    expect_all("rs.ign", 4, 1, 0, 0);
    tick = 1'b1;
    step(); step(); step();
    check("rs.c7", 32'(cnt), 7);
    step();
    expect_all("rs.term", 7, 0, 1, 1);
    step(); step();
    expect_all("rs.nowrap", 7, 0, 1, 0);

    // stop together with tick and start.
    do_start(3'd7, 1'b0);
    step(); step(); step(); step();
    check("st.pre", 32'(cnt), 4);
    start = 1'b1; stop = 1'b1; tick = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    expect_all("st.abort", 0, 0, 0, 0);

    // limit 0 auto-reload: tc stays high continuously.
    tick = 1'b1;
    do_start(3'd0, 1'b1);
    expect_all("l0.start", 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      expect_all("l0.run", 0, 1, 0, 1);
    end

    // Async reset mid-count at cnt=3.
    do_stop();
    tick = 1'b1;
    do_start(3'd7, 1'b1);
    step(); step(); step();
    check("ar.pre", 32'(cnt), 3);
    #2;
    rst = 1'b1;
    #1;
    expect_all("arst", 0, 0, 0, 0);
    step();
    expect_all("arst.held", 0, 0, 0, 0);
    rst = 1'b0;
    tick = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
